elastic_buffer_struct: RTL and testbench

Parametrised-depth elastic buffer for typed (struct) payloads with a valid/ready handshake on both sides. It replaces the single-entry skid stage between pipeline stages (decode→rename, rename→dispatch) where more than one cycle of decoupling is needed. It adds full-throughput back-to-back transfer, occupancy reporting, an almost-full early warning and a synchronous flush for misprediction recovery.

---
 rtl/elastic_buffer_struct.sv | 63 ++++++
 tb/tb_elastic_buffer_struct.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_buffer_struct.sv
// Elastic buffer for typed payloads: circular array with valid/ready on both
// sides, registered occupancy, almost-full warning and synchronous flush.
module elastic_buffer_struct #(
    parameter type T            = logic,
    parameter int  DEPTH        = 4,
    parameter int  AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  T                           data_in,
    output logic                       valid_out,
    input  logic                       ready_out,
    output T                           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL = CW'(AFULL_THRESH);

    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic          clear;

    // Status comes only from registered occupancy, so no in-to-out paths.
    assign ready_in    = (count != FULL);
    assign valid_out   = (count != '0);
    assign almost_full = (count >= AFULL);
    assign data_out    = mem[rd_ptr];

    assign clear = reset || flush;
    assign push  = valid_in && ready_in;
    assign pop   = valid_out && ready_out;

    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; a cleared cycle drops its push.
    always_ff @(posedge clk) begin
        if (!clear && push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_elastic_buffer_struct.sv
// Bench for elastic_buffer_struct: directed vector table, streaming and
// flush sequences, then random traffic against a queue reference model.
module tb_elastic_buffer_struct;
    typedef struct packed {
        logic [3:0] tag;
        logic [7:0] val;
    } pl_t;

    typedef struct {
        logic       flush;
        logic       vin;
        logic [7:0] din;
        logic       rout;
        int         ecnt;
        logic       erdy;
        logic       evout;
        logic       eaf;
        logic [7:0] edout;
    } vec_t;

    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       valid_in;
    logic       ready_in;
    pl_t        data_in;
    logic       valid_out;
    logic       ready_out;
    pl_t        data_out;
    logic [2:0] count;
    logic       almost_full;

    int npass;
    int ntotal;

    elastic_buffer_struct #(
        .T(pl_t),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .data_in(data_in),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .data_out(data_out),
        .count(count),
        .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pl_t mk(input logic [7:0] v);
        pl_t p;
        p.tag = v[3:0] ^ 4'h5;
        p.val = v;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic v, input pl_t d,
                         input logic r);
        flush     = f;
        valid_in  = v;
        data_in   = d;
        ready_out = r;
    endtask

    vec_t tbl[$];

    task automatic add(input logic f, input logic v, input logic [7:0] d,
                       input logic r, input int c, input logic rdy,
                       input logic vo, input logic af, input logic [7:0] dq);
        vec_t e;
        e.flush = f; e.vin = v; e.din = d; e.rout = r;
        e.ecnt = c; e.erdy = rdy; e.evout = vo; e.eaf = af; e.edout = dq;
        tbl.push_back(e);
    endtask

    pl_t q[$];
    int  xfers;
    logic held;
    logic m_push;
    logic m_pop;
    logic cl;

    initial begin
        npass  = 0;
        ntotal = 0;
        // fill with ready_out low, full-with-pop, drain, then flush at 3
        add(0, 1, 8'hA1, 0, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'hA2, 0, 1, 1, 1, 0, 8'hA1);
        add(0, 1, 8'hA3, 0, 2, 1, 1, 0, 8'hA1);
        add(0, 1, 8'hA4, 0, 3, 1, 1, 1, 8'hA1);
        add(0, 1, 8'hA5, 0, 4, 0, 1, 1, 8'hA1);
        add(0, 1, 8'hA5, 1, 4, 0, 1, 1, 8'hA1);
        add(0, 1, 8'hA5, 0, 3, 1, 1, 1, 8'hA2);
        add(0, 0, 8'h00, 1, 4, 0, 1, 1, 8'hA2);
        add(0, 0, 8'h00, 1, 3, 1, 1, 1, 8'hA3);
        add(0, 0, 8'h00, 1, 2, 1, 1, 0, 8'hA4);
        add(0, 0, 8'h00, 1, 1, 1, 1, 0, 8'hA5);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'h11, 0, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'h22, 0, 1, 1, 1, 0, 8'h11);
        add(0, 1, 8'h33, 0, 2, 1, 1, 0, 8'h11);
        add(1, 1, 8'h44, 1, 3, 1, 1, 1, 8'h11);
        add(0, 1, 8'h5C, 1, 0, 1, 0, 0, 8'h00);
        add(0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h5C);
        add(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00);

        reset = 1'b1;
        drive(0, 0, '0, 0);
        step();
        step();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            #2;
            chk("idle_ready_in", 32'(ready_in), 1);
            chk("idle_valid_out", 32'(valid_out), 0);
            chk("idle_count", 32'(count), 0);
            chk("idle_almost_full", 32'(almost_full), 0);
            step();
        end

        foreach (tbl[i]) begin
            drive(tbl[i].flush, tbl[i].vin, mk(tbl[i].din), tbl[i].rout);
            #2;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
            chk($sformatf("vec%0d_ready_in", i), 32'(ready_in),
                32'(tbl[i].erdy));
            chk($sformatf("vec%0d_valid_out", i), 32'(valid_out),
                32'(tbl[i].evout));
            chk($sformatf("vec%0d_almost_full", i), 32'(almost_full),
                32'(tbl[i].eaf));
            if (tbl[i].evout)
                chk($sformatf("vec%0d_data_out", i), 32'(data_out),
                    32'(mk(tbl[i].edout)));
            step();
        end

        // streaming: 16 values, one per cycle, count pinned at 1
        for (int i = 0; i <= 16; i++) begin
            drive(0, i < 16, mk(8'(i)), 1);
            #2;
            if (i == 0) begin
                chk("stream_fill_count", 32'(count), 0);
            end else begin
                chk($sformatf("stream%0d_count", i), 32'(count), 1);
                chk($sformatf("stream%0d_data", i), 32'(data_out),
                    32'(mk(8'(i - 1))));
            end
            step();
        end
        drive(0, 0, '0, 0);
        #2;
        chk("stream_drained", 32'(count), 0);

        // random traffic against queue model
        reset = 1'b1;
        step();
        reset = 1'b0;
        q.delete();
        xfers = 0;
        held  = 1'b0;
        for (int cyc = 0; cyc < 20000 && xfers < 1000; cyc++) begin
            if (!held) begin
                valid_in = 1'($urandom_range(1, 0));
                data_in  = pl_t'($urandom);
            end
            ready_out = 1'($urandom_range(1, 0));
            flush     = ($urandom_range(39, 0) == 0);
            reset     = ($urandom_range(199, 0) == 0);
            #2;
            chk("rnd_count", 32'(count), 32'(q.size()));
            chk("rnd_ready_in", 32'(ready_in), 32'(q.size() < DEPTH));
            chk("rnd_valid_out", 32'(valid_out), 32'(q.size() > 0));
            chk("rnd_almost_full", 32'(almost_full), 32'(q.size() >= AF));
            if (q.size() > 0)
                chk("rnd_data_out", 32'(data_out), 32'(q[0]));
            cl     = reset || flush;
            m_push = valid_in && (q.size() < DEPTH);
            m_pop  = ready_out && (q.size() > 0);
            step();
            if (cl) begin
                q.delete();
            end else begin
                if (m_pop) begin
                    void'(q.pop_front());
                    xfers++;
                end
                if (m_push) q.push_back(data_in);
            end
            held = valid_in && !m_push && !cl;
        end
        reset = 1'b0;
        chk("rnd_transfers_done", 32'(xfers >= 1000), 1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
